oversample_multi: RTL and testbench

- Parametrised, multi-channel oversampling decimator for the XADC sample stream.
- Generalises the fixed 16x/256x oversamplers into a single block.
  - Oversampling ratio is runtime-selectable as a power of two, 2^L with L = 0..MAX_LOG2.
  - Each channel tag keeps its own accumulator.
- Sits between the XADC DRP output and downstream consumers (PWM audio, FFT front end).
- Emits one full-scale-normalised result per completed window, each with a done pulse and a channel tag.

---
 rtl/oversample_multi.sv | 82 ++++++++
 tb/tb_oversample_multi.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/oversample_multi.sv
// oversample_multi: multi-channel power-of-two oversampling decimator for the XADC stream.
// Each channel accumulates 2^L samples and emits one full-scale-normalised result.
module oversample_multi #(
    parameter int SAMPLE_W = 12,
    parameter int MAX_LOG2 = 8,
    parameter int NCH      = 2,
    parameter int CH_W     = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [SAMPLE_W-1:0]            sample,
    input  logic [CH_W-1:0]                sample_ch,
    input  logic                           eoc,
    input  logic [3:0]                     ratio_sel,
    input  logic                           clear,
    output logic [SAMPLE_W+MAX_LOG2/2-1:0] oversample,
    output logic [CH_W-1:0]                out_ch,
    output logic                           done
);
    localparam int ACC_W = SAMPLE_W + MAX_LOG2;
    localparam int OUT_W = SAMPLE_W + MAX_LOG2 / 2;
    localparam int CW    = MAX_LOG2 + 1;

    logic [ACC_W-1:0]    acc [NCH];
    logic [MAX_LOG2-1:0] cnt [NCH];
    logic [3:0]          lat [NCH];
    logic [NCH-1:0]      hit;
    logic [ACC_W-1:0]    acc_s, sum, sh;
    logic [MAX_LOG2-1:0] cnt_s;
    logic [3:0]          lat_s, req_l, cur_l;
    logic                fin;

    // Only the addressed channel's state matters, so one shared datapath serves all channels.
    always_comb begin
        req_l = ratio_sel > 4'(MAX_LOG2) ? 4'(MAX_LOG2) : ratio_sel;
        hit   = '0;
        acc_s = '0;
        cnt_s = '0;
        lat_s = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i] = eoc && !clear && sample_ch == CH_W'(i);
            if (sample_ch == CH_W'(i)) begin
                acc_s = acc[i];
                cnt_s = cnt[i];
                lat_s = lat[i];
            end
        end
        cur_l = cnt_s == '0 ? req_l : lat_s;
        sum   = acc_s + ACC_W'(sample);
        fin   = ({1'b0, cnt_s} + CW'(1)) == (CW'(1) << cur_l);
        sh    = sum << (4'(MAX_LOG2) - cur_l);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oversample <= '0;
            out_ch     <= '0;
            done       <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
                lat[i] <= '0;
            end
        end else begin
            done <= |hit && fin;
            if (|hit && fin) begin
                oversample <= OUT_W'(sh >> (ACC_W - OUT_W));
                out_ch     <= sample_ch;
            end
            for (int i = 0; i < NCH; i++) begin
                if (clear) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end else if (hit[i]) begin
                    if (cnt[i] == '0) lat[i] <= req_l;
                    acc[i] <= fin ? '0 : sum;
                    cnt[i] <= fin ? '0 : cnt[i] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_oversample_multi.sv
// tb_oversample_multi: table-driven and scoreboard bench for oversample_multi.
module tb_oversample_multi;
    logic        clk = 0;
    logic        reset_n = 0;
    logic [11:0] sample = '0;
    logic        sample_ch = 0;
    logic        eoc = 0;
    logic [3:0]  ratio_sel = '0;
    logic        clear = 0;
    logic [15:0] oversample;
    logic        out_ch;
    logic        done;

    oversample_multi dut (
        .clk(clk), .reset_n(reset_n), .sample(sample), .sample_ch(sample_ch), .eoc(eoc),
        .ratio_sel(ratio_sel), .clear(clear), .oversample(oversample), .out_ch(out_ch), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  l;
        logic        ch;
        logic [11:0] s;
        int          n;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] val;
        logic        ch;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pops the oldest expectation; an unexpected or overdue done fails.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done with %h ch %0d, expected no done (cycle %0d)", oversample, out_ch, cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("oversample", {16'h0, oversample}, {16'h0, e.val});
                chk("out_ch", {31'h0, out_ch}, {31'h0, e.ch});
            end
        end else if (q.size() > 0 && cyc > q[0].due) begin
            checks++;
            fails++;
            $display("FAIL missing_done: got none, expected %h ch %0d at cycle %0d", q[0].val, q[0].ch, q[0].due);
            void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] l, input logic c, input logic [11:0] s,
                        input logic [15:0] e, input logic last);
        ratio_sel = l;
        sample_ch = c;
        sample    = s;
        eoc       = 1;
        if (last) q.push_back('{e, c, cyc + 1});
        tick();
    endtask

    task automatic idle(input int n);
        eoc = 0;
        repeat (n) tick();
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{4'd4,  1'b0, 12'hFFF, 16,  16'hFFF0};
        tbl[1] = '{4'd8,  1'b0, 12'h800, 256, 16'h8000};
        tbl[2] = '{4'd0,  1'b0, 12'hABC, 1,   16'hABC0};
        tbl[3] = '{4'd0,  1'b1, 12'h123, 1,   16'h1230};
        tbl[4] = '{4'd0,  1'b0, 12'h000, 1,   16'h0000};
        tbl[5] = '{4'd15, 1'b1, 12'h001, 256, 16'h0010};
        tbl[6] = '{4'd3,  1'b1, 12'h123, 8,   16'h1230};
        tbl[7] = '{4'd9,  1'b0, 12'hFFF, 256, 16'hFFF0};
        tbl[8] = '{4'd1,  1'b1, 12'h400, 2,   16'h4000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_oversample", {16'h0, oversample}, 32'h0);
        chk("reset_out_ch", {31'h0, out_ch}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        reset_n = 1;
        tick();

        // Rows 2..4 run back-to-back so passthrough done follows every eoc.
        for (int r = 0; r < 9; r++) begin
            for (int k = 0; k < tbl[r].n; k++)
                send(tbl[r].l, tbl[r].ch, tbl[r].s, tbl[r].exp, k == tbl[r].n - 1);
            if (r < 2 || r > 3) idle(2);
        end

        // Interleaved channels at L=1: completions on consecutive cycles.
        send(4'd1, 1'b0, 12'h100, 16'h0, 0);
        send(4'd1, 1'b1, 12'h010, 16'h0, 0);
        send(4'd1, 1'b0, 12'h300, 16'h2000, 1);
        send(4'd1, 1'b1, 12'h030, 16'h0200, 1);
        idle(3);
        chk("hold_oversample", {16'h0, oversample}, 32'h0200);
        chk("hold_out_ch", {31'h0, out_ch}, 32'h1);

        // Mid-window ratio change is ignored until the next window.
        send(4'd2, 1'b0, 12'h004, 16'h0, 0);
        send(4'd2, 1'b0, 12'h004, 16'h0, 0);
        send(4'd3, 1'b0, 12'h004, 16'h0, 0);
        send(4'd3, 1'b0, 12'h004, 16'h0040, 1);
        for (int k = 0; k < 8; k++) send(4'd3, 1'b0, 12'h004, 16'h0040, k == 7);
        idle(2);

        // Clear with a coincident eoc discards everything accumulated so far.
        for (int k = 0; k < 3; k++) send(4'd2, 1'b0, 12'h007, 16'h0, 0);
        clear = 1;
        send(4'd2, 1'b0, 12'h007, 16'h0, 0);
        clear = 0;
        idle(1);
        for (int k = 0; k < 4; k++) send(4'd2, 1'b0, 12'h001, 16'h0010, k == 3);
        idle(2);
        chk("clear_result_held", {16'h0, oversample}, 32'h0010);

        // Asynchronous reset mid-window abandons the partial window.
        for (int k = 0; k < 10; k++) send(4'd4, 1'b0, 12'hFFF, 16'h0, 0);
        eoc = 0;
        #1 reset_n = 0;
        #1;
        chk("async_oversample", {16'h0, oversample}, 32'h0);
        chk("async_out_ch", {31'h0, out_ch}, 32'h0);
        chk("async_done", {31'h0, done}, 32'h0);
        tick();
        reset_n = 1;
        tick();
        for (int k = 0; k < 16; k++) send(4'd4, 1'b0, 12'hFFF, 16'hFFF0, k == 15);
        idle(5);
        chk("scoreboard_empty", q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
